// File: rtl/vdemux_pkg.sv
// Shared constants and helpers for the N64 video demultiplexer.
package vdemux_pkg;

    localparam int NCSYNC_BIT = 0;
    localparam int NHSYNC_BIT = 1;
    localparam int NCLAMP_BIT = 2;
    localparam int NVSYNC_BIT = 3;

    localparam int MAX_NCH = 7;

    // Channel 0 in the LSBs: R drops 2, G drops 1, B drops 2.
    localparam logic [5:0] DEF_LSB_DROP = {2'd2, 2'd1, 2'd2};

    // Counter must hold 0..NCH+1, the top value meaning "past the frame".
    function automatic int count_w(input int nch);
        return $clog2(nch + 2);
    endfunction

    function automatic logic [1:0] drop_of(input logic [2*MAX_NCH-1:0] drops, input int ch);
        return drops[2*ch +: 2];
    endfunction

    function automatic logic [31:0] trim_lsbs(input logic [31:0] value, input logic [1:0] n);
        return value & ~((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/n64_vdemux_phase_chk.sv
// Frame-phase tracker: sample counter plus the per-sync complete/malformed decision.
// VDEMUX_PHASE_CHECK_EN enables dropping and reporting of malformed frames.
module n64_vdemux_phase_chk
    import vdemux_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int CNT_W = count_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    output logic [CNT_W-1:0] cnt,
    output logic             frame_ok,
    output logic             phase_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NCH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NCH + 1);

    logic frame_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= CNT_SAT;
            frame_seen <= 1'b0;
        end else if (sync) begin
            cnt        <= '0;
            frame_seen <= 1'b1;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef VDEMUX_PHASE_CHECK_EN
    assign frame_ok  = sync & frame_seen & (cnt == CNT_FULL);
    assign phase_err = sync & frame_seen & (cnt != CNT_FULL);
`else
    // Without the check every sync after the first presents whatever was captured.
    assign frame_ok  = sync & frame_seen;
    assign phase_err = 1'b0;
`endif

endmodule

// File: rtl/n64_vdemux_nch.sv
// N64 serial video demultiplexer: sync word plus NCH colour samples per nVDSYNC frame.
// Optional VDEMUX_PHASE_CHECK_EN drops malformed frames and pulses phase_err_o.
module n64_vdemux_nch
    import vdemux_pkg::*;
#(
    parameter int COLOR_W = 7,
    parameter int NCH     = 3,
    parameter int SYNC_W  = 4,
    parameter logic [2*NCH-1:0] LSB_DROP = (2*NCH)'(DEF_LSB_DROP)
) (
    input  logic                   VCLK,
    input  logic                   RST,
    input  logic                   nVDSYNC,
    input  logic [COLOR_W-1:0]     VD_i,
    input  logic                   palmode_i,
    input  logic                   ndo_deblur_i,
    input  logic                   n16bit_mode_i,
    output logic                   vsync_valid_o,
    output logic [SYNC_W-1:0]      vsync_o,
    output logic                   vdata_valid_o,
    output logic [SYNC_W-1:0]      vdata_sy_o,
    output logic [NCH*COLOR_W-1:0] vdata_co_o,
    output logic                   phase_err_o
);

    localparam int CNT_W = count_w(NCH);

    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   frame_ok;
    logic                   phase_err;
    logic [SYNC_W-1:0]      sync_q;
    logic [NCH*COLOR_W-1:0] col_q;
    logic [NCH*COLOR_W-1:0] trimmed;
    logic                   nblank;
    logic                   nblank_next;

    assign sync    = ~nVDSYNC;
    assign vsync_o = sync_q;

    n64_vdemux_phase_chk #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_phase_chk (
        .clk       (VCLK),
        .rst       (RST),
        .sync      (sync),
        .cnt       (cnt),
        .frame_ok  (frame_ok),
        .phase_err (phase_err)
    );

    always_comb begin
        trimmed = '0;
        for (int k = 0; k < NCH; k++) begin
            if (n16bit_mode_i)
                trimmed[k*COLOR_W +: COLOR_W] = VD_i;
            else
                trimmed[k*COLOR_W +: COLOR_W] =
                    COLOR_W'(trim_lsbs(32'(VD_i), drop_of((2*MAX_NCH)'(LSB_DROP), k)));
        end
    end

    // A rising nCSYNC re-aligns the blank phase to palmode; otherwise frames alternate.
    always_comb begin
        nblank_next = ~nblank;
        if (ndo_deblur_i)
            nblank_next = 1'b1;
        else if (!sync_q[NCSYNC_BIT] && VD_i[NCSYNC_BIT])
            nblank_next = palmode_i;
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            col_q <= '0;
        end else if (!sync) begin
            for (int k = 0; k < NCH; k++) begin
                if (cnt == CNT_W'(k))
                    col_q[k*COLOR_W +: COLOR_W] <= trimmed[k*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            sync_q        <= '0;
            nblank        <= 1'b1;
            vsync_valid_o <= 1'b0;
            vdata_valid_o <= 1'b0;
            vdata_sy_o    <= '0;
            vdata_co_o    <= '0;
            phase_err_o   <= 1'b0;
        end else begin
            vsync_valid_o <= sync;
            vdata_valid_o <= frame_ok;
            phase_err_o   <= phase_err;
            if (frame_ok) begin
                vdata_sy_o <= sync_q;
                // Gate with the blank phase that was in force while this frame was captured.
                if (nblank)
                    vdata_co_o <= col_q;
            end
            if (sync) begin
                sync_q <= VD_i[SYNC_W-1:0];
                nblank <= nblank_next;
            end
        end
    end

endmodule
